sw_debounce: RTL

- Board-side input conditioner for slide switches. It synchronises, debounces and change-detects a raw switch vector.
- It drives a clean `sw` vector into the LED/logic blocks in place of direct switch wiring.
- It also emits a one-cycle change strobe with a per-bit mask, for downstream capture.
- One instance sits between the top-level switch pins and all switch consumers.

---
 rtl/sw_debounce.sv | 74 +++++++
 1 files changed

// File: rtl/sw_debounce.sv
// Slide-switch conditioner: two-flop synchroniser, per-bit debounce counter and
// a registered one-cycle change strobe carrying the mask of bits that updated.
module sw_debounce #(
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned CNT_MAX = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic             sw_changed,
  output logic [WIDTH-1:0] change_mask
);

  localparam int unsigned   CW       = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CW-1:0]    cnt [WIDTH];
  logic [WIDTH-1:0] mismatch_c;
  logic [WIDTH-1:0] accept_c;

  // Two-flop synchroniser for the asynchronous switch pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
    end
  end

  // A bit accepts its new level on the edge its mismatch run reaches CNT_MAX.
  always_comb begin
    mismatch_c = sync2 ^ sw_clean;
    accept_c   = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      accept_c[i] = mismatch_c[i] && (cnt[i] == CNT_LAST);
    end
  end

  // Per-bit stability counters; any agreement or an accept restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (!mismatch_c[i] || accept_c[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Clean levels and the strobe/mask all update on the accepting edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_clean    <= '0;
      sw_changed  <= 1'b0;
      change_mask <= '0;
    end else begin
      sw_clean    <= sw_clean ^ accept_c;
      sw_changed  <= |accept_c;
      change_mask <= accept_c;
    end
  end

endmodule
